regfile_wb_scheduler: RTL and testbench

//  Shares the register file's single write port between two writeback sources: ALU (src0) and LSU (src1).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_wb_scheduler.sv | 123 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// The optional ALU starvation guard is enabled with RF_WB_FAIRNESS_EN.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 4;

  // Identifies which writeback source owns the write port in a cycle.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on register-file
// commit, with combinational busy/issue-ready lookups. x0 is never pending.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_issue_valid,
  input  logic [REG_AW-1:0] i_issue_rd,
  input  logic              i_rf_we,
  input  logic [REG_AW-1:0] i_rf_waddr,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  output logic              o_issue_free,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Decode this cycle's set (accepted issue) and clear (committing write) masks.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    set_mask = '0;
    clr_mask = '0;
    if (i_issue_valid && o_issue_free && (i_issue_rd != '0)) begin
      set_mask[i_issue_rd] = 1'b1;
    end
    if (i_rf_we) begin
      clr_mask[i_rf_waddr] = 1'b1;
    end
  end

  // Pending vector: clear first, then set, so a same-edge set wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: pending is a flop vector, not RAM, so it is reset like any state; a
    // stale bit after reset would stall decode forever.
    if (!i_reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign o_issue_free = (i_issue_rd == '0) || !pending[i_issue_rd];
  assign o_rs1_busy   = (i_rs1 != '0) && pending[i_rs1];
  assign o_rs2_busy   = (i_rs2 != '0) && pending[i_rs2];

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and LSU
// writeback, registers the winning write, and hosts the hazard scoreboard.
// Default priority is LSU over ALU. Defining RF_WB_FAIRNESS_EN adds a
// saturating ALU wait counter that hands the ALU the next contended cycle
// once it has waited MAX_WAIT cycles.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [REG_AW-1:0] i_alu_rd,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [REG_AW-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]   i_lsu_data,
  input  logic              i_issue_valid,
  input  logic [REG_AW-1:0] i_issue_rd,
  output logic              o_issue_ready,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_rf_we,
  output logic [REG_AW-1:0] o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata
);

  logic              alu_grant;
  logic              lsu_grant;
  logic              alu_priority;
  wb_src_t           win_src;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  logic              issue_free;

`ifdef RF_WB_FAIRNESS_EN
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Count cycles the ALU is left waiting; saturate, and restart on its grant.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wait_cnt <= '0;
    end else if (alu_grant) begin
      wait_cnt <= '0;
    end else if (i_alu_valid && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign alu_priority = (wait_cnt == WAIT_MAX);
`else
  assign alu_priority = 1'b0;
`endif

  // Grant at most one source; nothing is granted while reset is asserted.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    win_src   = WB_SRC_ALU;
    if (i_reset_n) begin
      if (i_lsu_valid && !(i_alu_valid && alu_priority)) begin
        lsu_grant = 1'b1;
        win_src   = WB_SRC_LSU;
      end else if (i_alu_valid) begin
        alu_grant = 1'b1;
      end
    end
  end

  // Steer the winner's destination and data toward the output register.
  always_comb begin
    if (win_src == WB_SRC_LSU) begin
      win_rd   = i_lsu_rd;
      win_data = i_lsu_data;
    end else begin
      win_rd   = i_alu_rd;
      win_data = i_alu_data;
    end
  end

  assign o_alu_ready = alu_grant;
  assign o_lsu_ready = lsu_grant;

  // Register the granted write; a write to x0 is accepted but never enabled.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!i_reset_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else if (alu_grant || lsu_grant) begin
      o_rf_we    <= (win_rd != '0);
      o_rf_waddr <= win_rd;
      o_rf_wdata <= win_data;
    end else begin
      o_rf_we    <= 1'b0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rf_we       (o_rf_we),
    .i_rf_waddr    (o_rf_waddr),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_issue_free  (issue_free),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy)
  );

  assign o_issue_ready = i_reset_n && issue_free;

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus
// randomized traffic compared against a behavioural model of the scheduler.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_alu_valid;
  logic              o_alu_ready;
  logic [REG_AW-1:0] i_alu_rd;
  logic [XLEN-1:0]   i_alu_data;
  logic              i_lsu_valid;
  logic              o_lsu_ready;
  logic [REG_AW-1:0] i_lsu_rd;
  logic [XLEN-1:0]   i_lsu_data;
  logic              i_issue_valid;
  logic [REG_AW-1:0] i_issue_rd;
  logic              o_issue_ready;
  logic [REG_AW-1:0] i_rs1;
  logic [REG_AW-1:0] i_rs2;
  logic              o_rs1_busy;
  logic              o_rs2_busy;
  logic              o_rf_we;
  logic [REG_AW-1:0] o_rf_waddr;
  logic [XLEN-1:0]   o_rf_wdata;

  regfile_wb_scheduler dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_alu_valid   (i_alu_valid),
    .o_alu_ready   (o_alu_ready),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_lsu_valid   (i_lsu_valid),
    .o_lsu_ready   (o_lsu_ready),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_issue_ready (o_issue_ready),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_rf_we       (o_rf_we),
    .o_rf_waddr    (o_rf_waddr),
    .o_rf_wdata    (o_rf_wdata)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: which registers await a write, the write visible on
  // the port, and how long the ALU has been kept waiting.
  bit          m_pending [NUM_REGS];
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // Decisions and combinational outputs observed in the last stepped cycle.
  bit g_alu, g_lsu;
  bit s_alu_ready, s_lsu_ready, s_issue_ready, s_rs1_busy, s_rs2_busy;

  function automatic void model_reset();
    foreach (m_pending[i]) m_pending[i] = 1'b0;
    m_wait  = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  task automatic idle();
    i_alu_valid   = 1'b0;
    i_lsu_valid   = 1'b0;
    i_issue_valid = 1'b0;
  endtask

  // One clock cycle: inputs are already applied after a falling edge.
  task automatic step();
    bit          e_issue_ready;
    bit          e_b1, e_b2;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    #1;
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (i_alu_valid && i_lsu_valid) begin
`ifdef RF_WB_FAIRNESS_EN
      if (m_wait >= MAX_WAIT) g_alu = 1'b1;
      else                    g_lsu = 1'b1;
`else
      g_lsu = 1'b1;
`endif
    end else begin
      g_alu = i_alu_valid;
      g_lsu = i_lsu_valid;
    end
    e_issue_ready = (i_issue_rd == 0) || !m_pending[i_issue_rd];
    e_b1 = (i_rs1 != 0) && m_pending[i_rs1];
    e_b2 = (i_rs2 != 0) && m_pending[i_rs2];
    s_alu_ready   = o_alu_ready;
    s_lsu_ready   = o_lsu_ready;
    s_issue_ready = o_issue_ready;
    s_rs1_busy    = o_rs1_busy;
    s_rs2_busy    = o_rs2_busy;
    check("alu_ready", o_alu_ready, g_alu);
    check("lsu_ready", o_lsu_ready, g_lsu);
    check("issue_ready", o_issue_ready, e_issue_ready);
    check("rs1_busy", o_rs1_busy, e_b1);
    check("rs2_busy", o_rs2_busy, e_b2);
    @(posedge i_clk);
    // Commit of the old write clears, then an accepted issue sets (set wins).
    if (m_we) m_pending[m_waddr] = 1'b0;
    if (i_issue_valid && e_issue_ready && i_issue_rd != 0) m_pending[i_issue_rd] = 1'b1;
    m_we = 1'b0;
    if (g_alu || g_lsu) begin
      w_rd    = g_lsu ? i_lsu_rd   : i_alu_rd;
      w_data  = g_lsu ? i_lsu_data : i_alu_data;
      m_we    = (w_rd != 0);
      m_waddr = w_rd;
      m_wdata = w_data;
    end
    if (g_alu)                                  m_wait = 0;
    else if (i_alu_valid && m_wait < MAX_WAIT)  m_wait++;
    #1;
    check("rf_we", o_rf_we, m_we);
    if (m_we) begin
      check("rf_waddr", o_rf_waddr, m_waddr);
      check("rf_wdata", o_rf_wdata, m_wdata);
    end
    @(negedge i_clk);
  endtask

  int first_alu;

  initial begin
    i_reset_n     = 1'b0;
    i_alu_valid   = 1'b1;
    i_lsu_valid   = 1'b1;
    i_issue_valid = 1'b1;
    i_alu_rd      = 5'd1;
    i_alu_data    = 32'h1;
    i_lsu_rd      = 5'd2;
    i_lsu_data    = 32'h2;
    i_issue_rd    = 5'd3;
    i_rs1         = 5'd3;
    i_rs2         = 5'd4;
    model_reset();

    // Reset state, with every request asserted.
    #12;
    check("rst_we", o_rf_we, 0);
    check("rst_waddr", o_rf_waddr, 0);
    check("rst_wdata", o_rf_wdata, 0);
    check("rst_alu_ready", o_alu_ready, 0);
    check("rst_lsu_ready", o_lsu_ready, 0);
    check("rst_issue_ready", o_issue_ready, 0);
    check("rst_rs1_busy", o_rs1_busy, 0);
    idle();
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // 1. Lone ALU write.
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    step();
    check("t1_ready", s_alu_ready, 1);
    check("t1_we", o_rf_we, 1);
    check("t1_waddr", o_rf_waddr, 5);
    check("t1_wdata", o_rf_wdata, 32'hDEADBEEF);
    idle();
    step();
    check("t1_we_fall", o_rf_we, 0);

    // 2. Contention: LSU first, then ALU.
    i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h3333;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = 32'h4444;
    step();
    check("t2_lsu_first", s_lsu_ready, 1);
    check("t2_alu_held", s_alu_ready, 0);
    check("t2_waddr_lsu", o_rf_waddr, 4);
    i_lsu_valid = 1'b0;
    step();
    check("t2_alu_second", s_alu_ready, 1);
    check("t2_waddr_alu", o_rf_waddr, 3);
    idle();
    step();

    // 3. LSU streams continuously while the ALU waits.
    first_alu = 0;
    i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 32'hA1A1;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd11; i_lsu_data = 32'hB2B2;
    for (int c = 1; c <= 8 && first_alu == 0; c++) begin
      step();
      if (s_alu_ready) first_alu = c;
    end
`ifdef RF_WB_FAIRNESS_EN
    check("t3_alu_grant_cycle", first_alu, MAX_WAIT + 1);
`else
    check("t3_alu_starved", first_alu, 0);
`endif
    i_lsu_valid = 1'b0;
    step();
    check("t3_alu_after_lsu", s_alu_ready, 1);
    idle();
    step();

    // 4. RAW/WAW hazard on x7 and its release after the commit.
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    step();
    check("t4_first_issue", s_issue_ready, 1);
    i_rs1 = 5'd7;
    step();
    check("t4_rs1_busy", s_rs1_busy, 1);
    check("t4_waw_block", s_issue_ready, 0);
    i_issue_valid = 1'b0;
    i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h7777;
    step();
    idle();
    step();
    check("t4_busy_during_commit", s_rs1_busy, 1);
    step();
    check("t4_busy_cleared", s_rs1_busy, 0);
    check("t4_issue_free", s_issue_ready, 1);

    // 5. Writes and issues to x0.
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h1234;
    step();
    check("t5_x0_ready", s_alu_ready, 1);
    check("t5_x0_no_we", o_rf_we, 0);
    idle();
    i_issue_valid = 1'b1; i_issue_rd = 5'd0; i_rs1 = 5'd0;
    step();
    check("t5_x0_issue", s_issue_ready, 1);
    step();
    check("t5_x0_not_busy", s_rs1_busy, 0);
    check("t5_x0_issue_again", s_issue_ready, 1);
    idle();

    // Randomized traffic; a source that was not accepted holds its request.
    for (int n = 0; n < 400; n++) begin
      if (!(i_alu_valid && !g_alu)) begin
        i_alu_valid = ($urandom_range(0, 2) != 0);
        i_alu_rd    = 5'($urandom_range(0, 7));
        i_alu_data  = $urandom;
      end
      if (!(i_lsu_valid && !g_lsu)) begin
        i_lsu_valid = ($urandom_range(0, 1) != 0);
        i_lsu_rd    = 5'($urandom_range(0, 7));
        i_lsu_data  = $urandom;
      end
      i_issue_valid = ($urandom_range(0, 2) == 0);
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_rs1         = 5'($urandom_range(0, 7));
      i_rs2         = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    // 6. Reset while a write is registered and x9 is pending.
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h9999;
    i_lsu_valid = 1'b0;
    step();
    check("t6_we_before", o_rf_we, 1);
    i_lsu_valid = 1'b1; i_rs1 = 5'd9; i_issue_rd = 5'd12;
    i_reset_n = 1'b0;
    #1;
    check("t6_we_dropped", o_rf_we, 0);
    check("t6_rs1_clear", o_rs1_busy, 0);
    check("t6_alu_ready", o_alu_ready, 0);
    check("t6_lsu_ready", o_lsu_ready, 0);
    check("t6_issue_ready", o_issue_ready, 0);
    @(posedge i_clk);
    #1;
    check("t6_we_held_low", o_rf_we, 0);
    @(negedge i_clk);
    idle();
    i_reset_n = 1'b1;
    model_reset();
    step();
    check("t6_after_release", s_rs1_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_scheduler
